// File: rtl/load_value_scheduler_pkg.sv
// Shared types and constants for the load value scheduler and its arbiter.
package load_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_WRAP = 2'd2,
    DONE      = 2'd3
  } state_e;

  localparam int LOADS_DONE_W = 8;

  // Terminal count of a free-running counter of the given width.
  function automatic int max_count(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/load_value_scheduler_if.sv
// Requester, counter-side and status signals of the load value scheduler.
interface load_value_scheduler_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4
);
  import load_sched_pkg::*;

  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       Req;
  logic [NUM_REQ*WIDTH-1:0] Req_Value;
  logic [NUM_REQ-1:0]       Ack;
  logic                     Busy;
  logic [IDW-1:0]           Grant_Id;
  logic                     Load_Value_Valid;
  logic [WIDTH-1:0]         Load_Value;
  logic [WIDTH-1:0]         Count;
  logic [LOADS_DONE_W-1:0]  Loads_Done;

  // The scheduler is the slave of the requesters and watches the counter.
  modport slave (
    input  Req, Req_Value, Count,
    output Ack, Busy, Grant_Id, Load_Value_Valid, Load_Value, Loads_Done
  );

  modport master (
    output Req, Req_Value, Count,
    input  Ack, Busy, Grant_Id, Load_Value_Valid, Load_Value, Loads_Done
  );

endinterface

// File: rtl/load_value_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     grant,
  output logic               any_req
);

  int idx;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path infers a latch.
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[idx[IDW-1:0]]) begin
        any_req = 1'b1;
        grant   = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/load_value_scheduler.sv
// Arbitrates requesters onto a shared load value counter and acknowledges each
// winner once the counter has actually taken its value at the wrap.
module load_value_scheduler
  import load_sched_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4
) (
  input logic                  Clk,
  input logic                  Rst_l,
  load_value_scheduler_if.slave bus
);

  localparam int               IDW     = $clog2(NUM_REQ);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(max_count(WIDTH));

  state_e                  state_q, state_d;
  logic [IDW-1:0]          grant_id_q, grant_id_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]        load_value_q, load_value_d;
  logic                    lvv_q, lvv_d;
  logic                    busy_q, busy_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [LOADS_DONE_W-1:0] loads_done_q, loads_done_d;

  logic [IDW-1:0] arb_grant;
  logic           arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (bus.Req),
    .ptr     (rr_ptr_q),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    load_value_d = load_value_q;
    loads_done_d = loads_done_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d      = ISSUE;
          grant_id_d   = arb_grant;
          load_value_d = bus.Req_Value[int'(arb_grant)*WIDTH +: WIDTH];
          rr_ptr_d     = (arb_grant == IDW'(NUM_REQ-1)) ? '0 : arb_grant + 1'b1;
        end
      end
      ISSUE:     state_d = WAIT_WRAP;
      // The counter flag is armed here, so the next wrap loads our value.
      WAIT_WRAP: begin
        if (bus.Count == CNT_MAX) begin
          state_d = DONE;
          if (loads_done_q != '1) loads_done_d = loads_done_q + 1'b1;
        end
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave flops directly.
    lvv_d  = (state_d == ISSUE);
    busy_d = (state_d != IDLE);
    ack_d  = '0;
    if (state_d == DONE) ack_d[grant_id_d] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      rr_ptr_q     <= '0;
      load_value_q <= '0;
      lvv_q        <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= '0;
      loads_done_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from pre-edge values.
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      rr_ptr_q     <= rr_ptr_d;
      load_value_q <= load_value_d;
      lvv_q        <= lvv_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      loads_done_q <= loads_done_d;
    end
  end

  assign bus.Ack              = ack_q;
  assign bus.Busy             = busy_q;
  assign bus.Grant_Id         = grant_id_q;
  assign bus.Load_Value_Valid = lvv_q;
  assign bus.Load_Value       = load_value_q;
  assign bus.Loads_Done       = loads_done_q;

endmodule

// File: tb/tb_load_value_scheduler.sv
// Directed bench for load_value_scheduler with a behavioural load value counter.
module tb_load_value_scheduler;

  logic clk;
  logic rst_n;
  logic armed;
  int   n_cmp;
  int   n_err;

  load_value_scheduler_if #(.WIDTH(4), .NUM_REQ(4)) bus ();

  load_value_scheduler #(.WIDTH(4), .NUM_REQ(4)) dut (
    .Clk   (clk),
    .Rst_l (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter contract: free-running; a valid pulse arms a flag, armed wrap loads.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Count <= '0;
      armed     <= 1'b0;
    end else begin
      if (bus.Load_Value_Valid) armed <= 1'b1;
      if (armed && bus.Count == 4'hF) begin
        bus.Count <= bus.Load_Value;
        armed     <= 1'b0;
      end else begin
        bus.Count <= bus.Count + 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int budget, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.Ack != '0) seen = 1'b1;
    end
    if (!seen) check("ack_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_idle_count(input logic [3:0] v);
    int n;
    n = 0;
    while (!(bus.Count == v && !bus.Busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_count_timeout", 32'(bus.Count), 32'(v));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    int acks;
    int quiet_acks;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.Req       = '0;
    bus.Req_Value = '0;
    @(negedge clk);

    // Reset state.
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_ack", 32'(bus.Ack), 32'd0);
    check("rst_lvv", 32'(bus.Load_Value_Valid), 32'd0);
    check("rst_lv", 32'(bus.Load_Value), 32'd0);
    check("rst_gid", 32'(bus.Grant_Id), 32'd0);
    check("rst_done", 32'(bus.Loads_Done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: Req[0]=5 sampled at Count=2 -> ISSUE at 3, Ack 13 cycles later at Count=5.
    wait_idle_count(4'd2);
    bus.Req       = 4'b0001;
    bus.Req_Value = {4'd0, 4'd0, 4'd0, 4'd5};
    @(negedge clk);
    check("t1_issue_lvv", 32'(bus.Load_Value_Valid), 32'd1);
    check("t1_issue_cnt", 32'(bus.Count), 32'd3);
    check("t1_issue_busy", 32'(bus.Busy), 32'd1);
    check("t1_issue_gid", 32'(bus.Grant_Id), 32'd0);
    check("t1_issue_lv", 32'(bus.Load_Value), 32'd5);
    @(negedge clk);
    check("t1_wait_lvv", 32'(bus.Load_Value_Valid), 32'd0);
    check("t1_wait_lv", 32'(bus.Load_Value), 32'd5);
    wait_ack(40, cyc);
    check("t1_ack_lat", 32'(cyc + 1), 32'd13);
    check("t1_ack", 32'(bus.Ack), 32'b0001);
    check("t1_ack_cnt", 32'(bus.Count), 32'd5);
    check("t1_done", 32'(bus.Loads_Done), 32'd1);
    bus.Req = '0;
    @(negedge clk);
    check("t1_after_ack", 32'(bus.Ack), 32'd0);
    check("t1_after_busy", 32'(bus.Busy), 32'd0);

    // T2: ISSUE at Count=15 -> no load at that wrap; Ack 17 cycles after ISSUE.
    wait_idle_count(4'd14);
    bus.Req       = 4'b0010;
    bus.Req_Value = {4'd0, 4'd0, 4'd7, 4'd0};
    @(negedge clk);
    check("t2_issue_cnt", 32'(bus.Count), 32'd15);
    check("t2_issue_gid", 32'(bus.Grant_Id), 32'd1);
    wait_ack(40, cyc);
    check("t2_ack_lat", 32'(cyc), 32'd17);
    check("t2_ack", 32'(bus.Ack), 32'b0010);
    check("t2_ack_cnt", 32'(bus.Count), 32'd7);
    check("t2_done", 32'(bus.Loads_Done), 32'd2);
    bus.Req = '0;

    // T5: reset during WAIT_WRAP; pointer now 2 so Req[3] wins first.
    wait_idle_count(4'd0);
    bus.Req       = 4'b1000;
    bus.Req_Value = {4'd2, 4'd0, 4'd0, 4'd0};
    @(negedge clk);
    check("t5_issue_gid", 32'(bus.Grant_Id), 32'd3);
    bus.Req = '0;
    @(negedge clk);
    @(negedge clk);
    check("t5_wait_busy", 32'(bus.Busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(bus.Busy), 32'd0);
    check("t5_rst_ack", 32'(bus.Ack), 32'd0);
    check("t5_rst_lvv", 32'(bus.Load_Value_Valid), 32'd0);
    check("t5_rst_done", 32'(bus.Loads_Done), 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.Req       = 4'b0010;
    bus.Req_Value = {4'd0, 4'd0, 4'd6, 4'd0};
    @(negedge clk);
    check("t5_regrant_gid", 32'(bus.Grant_Id), 32'd1);
    check("t5_regrant_cnt", 32'(bus.Count), 32'd1);
    wait_ack(40, cyc);
    check("t5_ack_lat", 32'(cyc), 32'd15);
    check("t5_ack", 32'(bus.Ack), 32'b0010);
    check("t5_ack_cnt", 32'(bus.Count), 32'd6);
    check("t5_done", 32'(bus.Loads_Done), 32'd1);
    bus.Req = '0;

    // T3: all four requesting from pointer 0 -> grants 0,1,2,3,0.
    apply_reset();
    bus.Req       = 4'b1111;
    bus.Req_Value = {4'd4, 4'd3, 4'd2, 4'd1};
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, cyc);
      check($sformatf("t3_ack%0d", k), 32'(bus.Ack), 32'(1 << (k % 4)));
      check($sformatf("t3_gid%0d", k), 32'(bus.Grant_Id), 32'(k % 4));
      check($sformatf("t3_cnt%0d", k), 32'(bus.Count), 32'((k % 4) + 1));
    end
    bus.Req = '0;
    check("t3_done", 32'(bus.Loads_Done), 32'd5);

    // T4: Req[2] pulsed for its sample cycle only; later Req_Value edits ignored.
    @(negedge clk);
    check("t4_idle", 32'(bus.Busy), 32'd0);
    bus.Req       = 4'b0100;
    bus.Req_Value = {4'd0, 4'd9, 4'd0, 4'd0};
    @(negedge clk);
    check("t4_issue_gid", 32'(bus.Grant_Id), 32'd2);
    bus.Req       = '0;
    bus.Req_Value = {4'd0, 4'hF, 4'd0, 4'd0};
    wait_ack(40, cyc);
    check("t4_ack", 32'(bus.Ack), 32'b0100);
    check("t4_ack_cnt", 32'(bus.Count), 32'd9);
    quiet_acks = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.Ack != '0) quiet_acks++;
    end
    check("t4_single_ack", 32'(quiet_acks), 32'd0);
    check("t4_idle_after", 32'(bus.Busy), 32'd0);

    // T6: 260 back-to-back all-ones loads -> Loads_Done saturates at 255.
    apply_reset();
    bus.Req       = 4'b0001;
    bus.Req_Value = {4'd0, 4'd0, 4'd0, 4'hF};
    acks = 0;
    while (acks < 260) begin
      wait_ack(40, cyc);
      if (cyc >= 40) break;
      acks++;
      if (acks == 1)   check("t6_ack_cnt_max", 32'(bus.Count), 32'd15);
      if (acks == 2)   check("t6_period", 32'(cyc), 32'd17);
      if (acks == 254) check("t6_done254", 32'(bus.Loads_Done), 32'd254);
      if (acks == 255) check("t6_done255", 32'(bus.Loads_Done), 32'd255);
      if (acks == 256) check("t6_sat256", 32'(bus.Loads_Done), 32'd255);
      if (acks == 260) check("t6_sat260", 32'(bus.Loads_Done), 32'd255);
    end
    check("t6_acks", 32'(acks), 32'd260);
    bus.Req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_value_scheduler.md
Name: load_value_scheduler

Overview:
- Shares one Load Value Counter between NUM_REQ requesters.
- Round-robin arbitrates pending load requests and drives the counter's Load_Value_Valid/Load_Value.
- Monitors the counter's Count to detect when the load has taken effect, then acknowledges the winning requester.
- Sits beside the counter; both share Clk/Rst_l.

Parameters:
WIDTH, 4, counter/load value width (must match counter)
NUM_REQ, 4, number of requesters (2..8)
IDW, $clog2(NUM_REQ), requester index width (derived, localparam)

Ports:
Clk  input  1  clock, rising edge
Rst_l  input  1  asynchronous active-low reset
Req  input  NUM_REQ  per-requester load request, level, held until Ack
Req_Value  input  NUM_REQ*WIDTH  flattened load values, requester i at [i*WIDTH +: WIDTH]
Ack  output  NUM_REQ  one-cycle pulse: requester's value now loaded into counter
Busy  output  1  high whenever state != IDLE
Grant_Id  output  IDW  index of the current grant, valid while Busy
Load_Value_Valid  output  1  to counter, one-cycle pulse
Load_Value  output  WIDTH  to counter, held stable from ISSUE through WAIT_WRAP
Count  input  WIDTH  counter output, observed
Loads_Done  output  8  saturating count of completed loads

Behaviour:
- Reset (async, Rst_l low): state=IDLE; Ack, Busy, Grant_Id, Load_Value_Valid, Load_Value, Loads_Done all 0; RR pointer=0.
- Counter contract, fixed: increments every cycle and wraps; a Load_Value_Valid pulse arms a pending flag on the following edge; when the flag is armed and Count==2**WIDTH-1, the next Count is Load_Value and the flag clears.
- FSM states:
  - IDLE: if any Req bit is high, the rr_arbiter picks the first requesting index at or after the RR pointer (wrapping). On that edge: latch Grant_Id, latch Load_Value from Req_Value[grant], set RR pointer=grant+1 mod NUM_REQ, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: Load_Value_Valid=1 for exactly this cycle; always go to WAIT_WRAP.
  - WAIT_WRAP: the counter flag is guaranteed armed. On the first cycle with Count==2**WIDTH-1, go to DONE. The first WAIT_WRAP cycle counts, even if Count is already max.
  - DONE: Ack[Grant_Id]=1 for this cycle only. Count equals the loaded value in this cycle. Loads_Done increments, saturating at 255. Go to IDLE.
- Latency:
  - Req seen in IDLE at cycle c gives ISSUE at c+1.
  - Ack arrives 1..2**WIDTH cycles after the WAIT_WRAP entry (c+2).
  - Minimum request-to-request spacing for one grant is 4 cycles.
- ISSUE with Count==max: the pending flag is not yet armed, so no load happens at that wrap. WAIT_WRAP then lasts a full 2**WIDTH cycles.
- Req deasserted after grant: the transaction still completes and Ack still pulses. Req changes after the latch cycle are ignored. Req_Value changes after latch have no effect.
- A requester that keeps Req high after its Ack re-enters arbitration at lowest priority (pointer advanced). No starvation: worst-case wait is NUM_REQ transactions.
- Load_Value of all-ones is legal: the counter loads max, the flag clears, and counting continues normally.
- Reset mid-transaction: immediate return to IDLE with no Ack. The counter resets on the same Rst_l, so no stale load survives.
- Ack is one-hot or zero. Load_Value_Valid never asserts outside ISSUE. All outputs are registered.

Decomposition:
- Package load_sched_pkg: state enum (IDLE, ISSUE, WAIT_WRAP, DONE) as 2-bit typedef; function max_count(WIDTH) returning 2**WIDTH-1; LOADS_DONE_W=8.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and pointer; outputs grant index and any_req. Purely combinational; the pointer register lives in the parent.

Test Plan:
1. WIDTH=4, NUM_REQ=4; Req[0]=1 with value 5, sampled in IDLE while Count=2 -> ISSUE at Count=3; WAIT_WRAP until Count=15; next cycle Count=5, Ack=4'b0001, Loads_Done=1.
2. Req sampled so ISSUE coincides with Count=15 -> no load at that wrap; WAIT_WRAP spans Count 0..15 (16 cycles); Ack on the cycle where Count=load value.
3. Req=4'b1111 held, values 1,2,3,4 -> grants 0,1,2,3 in order, then 0 again; each Ack coincides with Count equal to that requester's value.
4. Req[2] pulses only during its IDLE sample cycle, value 9 -> transaction completes; Ack[2] pulses once with Count=9.
5. Rst_l low during WAIT_WRAP -> Busy=0, Ack=0, Load_Value_Valid=0 immediately; after release with Req[1]=1, the grant goes to index 1 starting from pointer 0.
6. 260 back-to-back completions -> Loads_Done saturates at 255 and holds.
